// File: rtl/spi_pkg.sv
// Shared SPI link definitions: word geometry and receiver state encoding.
// The transmitter and receiver both import this package.
package spi_pkg;

    localparam int SPI_WORD_W = 16;
    localparam int SPI_CNT_W  = 5;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        RECV      = 2'd2
    } rx_state_t;

endpackage

// File: rtl/spi_in_sync.sv
// Input conditioning for the SPI receiver: optional synchroniser chain on
// cs_l/sclk/data plus rising-edge detect on the conditioned sclk.
module spi_in_sync
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic cs_l,
    input  logic sclk,
    input  logic data,
    output logic cs_s,
    output logic sclk_s,
    output logic data_s,
    output logic sclk_rise,
    output logic sync_valid
);

    logic sclk_q;
    logic sclk_d;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign cs_s       = cs_l;
            assign sclk_s     = sclk;
            assign data_s     = data;
            assign sync_valid = 1'b1;
        end else begin : g_sync
            localparam int FILL_W = $clog2(SYNC_STAGES + 1);

            logic [SYNC_STAGES-1:0] cs_pipe_q;
            logic [SYNC_STAGES-1:0] cs_pipe_d;
            logic [SYNC_STAGES-1:0] sclk_pipe_q;
            logic [SYNC_STAGES-1:0] sclk_pipe_d;
            logic [SYNC_STAGES-1:0] data_pipe_q;
            logic [SYNC_STAGES-1:0] data_pipe_d;
            logic [FILL_W-1:0]      fill_q;
            logic [FILL_W-1:0]      fill_d;

            for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
                if (gi == 0) begin : g_head
                    assign cs_pipe_d[gi]   = cs_l;
                    assign sclk_pipe_d[gi] = sclk;
                    assign data_pipe_d[gi] = data;
                end else begin : g_tail
                    assign cs_pipe_d[gi]   = cs_pipe_q[gi-1];
                    assign sclk_pipe_d[gi] = sclk_pipe_q[gi-1];
                    assign data_pipe_d[gi] = data_pipe_q[gi-1];
                end
            end

            // The chain comes out of reset holding an idle image rather than
            // real samples; sync_valid tells the FSM when the idle image has
            // been flushed so a held-low cs_l is not mistaken for a clean start.
            always_comb begin
                fill_d = fill_q;
                if (fill_q != FILL_W'(SYNC_STAGES)) begin
                    fill_d = fill_q + FILL_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cs_pipe_q   <= '1;
                    sclk_pipe_q <= '0;
                    data_pipe_q <= '0;
                    fill_q      <= '0;
                end else begin
                    cs_pipe_q   <= cs_pipe_d;
                    sclk_pipe_q <= sclk_pipe_d;
                    data_pipe_q <= data_pipe_d;
                    fill_q      <= fill_d;
                end
            end

            assign cs_s       = cs_pipe_q[SYNC_STAGES-1];
            assign sclk_s     = sclk_pipe_q[SYNC_STAGES-1];
            assign data_s     = data_pipe_q[SYNC_STAGES-1];
            assign sync_valid = (fill_q == FILL_W'(SYNC_STAGES));
        end
    endgenerate

    assign sclk_d = sclk_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_q <= 1'b0;
        end else begin
            sclk_q <= sclk_d;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_q;

endmodule

// File: rtl/spi_rx_slave.sv
// SPI (CPOL=0) receive slave: deserialises words framed by spi_cs_l,
// pulses data_valid per completed word and frame_err on partial frames.
module spi_rx_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_WORD_W,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_cs_l,
    input  logic                 spi_sclk,
    input  logic                 spi_data,
    output logic [DATA_W-1:0]    dataout,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic [SPI_CNT_W-1:0] bit_count,
    output logic                 busy
);

    localparam logic [SPI_CNT_W-1:0] LAST_BIT = SPI_CNT_W'(DATA_W - 1);

    logic cs_s;
    logic sclk_s;
    logic data_s;
    logic sclk_rise;
    logic sync_valid;

    spi_in_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_in_sync (
        .clk        (clk),
        .reset      (reset),
        .cs_l       (spi_cs_l),
        .sclk       (spi_sclk),
        .data       (spi_data),
        .cs_s       (cs_s),
        .sclk_s     (sclk_s),
        .data_s     (data_s),
        .sclk_rise  (sclk_rise),
        .sync_valid (sync_valid)
    );

    rx_state_t            state_q,      state_d;
    logic [DATA_W-1:0]    shift_q,      shift_d;
    logic [DATA_W-1:0]    dataout_q,    dataout_d;
    logic [SPI_CNT_W-1:0] bit_count_q,  bit_count_d;
    logic                 word_done_q,  word_done_d;
    logic                 data_valid_q, data_valid_d;
    logic                 frame_err_q,  frame_err_d;
    logic                 busy_q,       busy_d;
    logic [DATA_W-1:0]    shift_in;

    assign shift_in = MSB_FIRST ? {shift_q[DATA_W-2:0], data_s}
                                : {data_s, shift_q[DATA_W-1:1]};

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        dataout_d    = dataout_q;
        bit_count_d  = bit_count_q;
        word_done_d  = 1'b0;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        // A word completed on the previous edge: publish it now. The shift
        // register cannot move again this cycle since sclk_q is still high.
        if (word_done_q) begin
            dataout_d    = shift_q;
            data_valid_d = 1'b1;
        end

        case (state_q)
            WAIT_IDLE: begin
                if (cs_s && sync_valid) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (!cs_s) begin
                    state_d     = RECV;
                    bit_count_d = '0;
                end
            end
            RECV: begin
                // Deselect takes priority over a coincident sclk rise.
                if (cs_s) begin
                    state_d     = IDLE;
                    frame_err_d = (bit_count_q != '0);
                    bit_count_d = '0;
                    shift_d     = '0;
                end else if (sclk_rise) begin
                    shift_d = shift_in;
                    if (bit_count_q == LAST_BIT) begin
                        word_done_d = 1'b1;
                        bit_count_d = '0;
                    end else begin
                        bit_count_d = bit_count_q + SPI_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = WAIT_IDLE;
            end
        endcase

        busy_d = (state_d == RECV);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WAIT_IDLE;
            shift_q      <= '0;
            dataout_q    <= '0;
            bit_count_q  <= '0;
            word_done_q  <= 1'b0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            dataout_q    <= dataout_d;
            bit_count_q  <= bit_count_d;
            word_done_q  <= word_done_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign dataout    = dataout_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign bit_count  = bit_count_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_spi_rx_slave.sv
// Bench for spi_rx_slave: three variants (MSB/sync0, LSB/sync0, MSB/sync2)
// share one SPI bus; a frame-level model predicts words and frame errors.
`timescale 1ns/1ps
module tb_spi_rx_slave;
    import spi_pkg::*;

    localparam int W    = 16;
    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic spi_cs_l = 1'b1;
    logic spi_sclk = 1'b0;
    logic spi_data = 1'b0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] dout [NDUT];
    logic         dv   [NDUT];
    logic         ferr [NDUT];
    logic [4:0]   bc   [NDUT];
    logic         bsy  [NDUT];

    spi_rx_slave #(.DATA_W(W), .MSB_FIRST(1'b1), .SYNC_STAGES(0)) u_msb (
        .clk(clk), .reset(reset), .spi_cs_l(spi_cs_l), .spi_sclk(spi_sclk), .spi_data(spi_data),
        .dataout(dout[0]), .data_valid(dv[0]), .frame_err(ferr[0]), .bit_count(bc[0]), .busy(bsy[0]));
    spi_rx_slave #(.DATA_W(W), .MSB_FIRST(1'b0), .SYNC_STAGES(0)) u_lsb (
        .clk(clk), .reset(reset), .spi_cs_l(spi_cs_l), .spi_sclk(spi_sclk), .spi_data(spi_data),
        .dataout(dout[1]), .data_valid(dv[1]), .frame_err(ferr[1]), .bit_count(bc[1]), .busy(bsy[1]));
    spi_rx_slave #(.DATA_W(W), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u_sync (
        .clk(clk), .reset(reset), .spi_cs_l(spi_cs_l), .spi_sclk(spi_sclk), .spi_data(spi_data),
        .dataout(dout[2]), .data_valid(dv[2]), .frame_err(ferr[2]), .bit_count(bc[2]), .busy(bsy[2]));

    localparam int LAT [NDUT] = '{2, 2, 4};

    typedef struct {
        bit           is_err;
        logic [W-1:0] w_msb;
        logic [W-1:0] w_lsb;
    } ev_t;

    typedef struct {
        logic [W-1:0] tx;
        int           nbits;
        logic [W-1:0] exp0;
        logic [W-1:0] exp1;
        int           exp_err;
    } vec_t;

    ev_t  exp_q[$];
    int   rd_idx   [NDUT];
    int   dv_cnt   [NDUT];
    int   ferr_cnt [NDUT];
    int   dv_cyc   [NDUT];
    int   dv_cyc_prev [NDUT];
    logic prev_dv  [NDUT];
    logic prev_fe  [NDUT];
    int   last_e1 = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: every complete group of W bits is one word,
    // any leftover bits at deselect make one frame error.
    task automatic model_frame(input bit bits[$]);
        int n;
        ev_t e;
        n = bits.size();
        for (int k = 0; k + W <= n; k += W) begin
            int unsigned m, l;
            m = 0;
            l = 0;
            for (int j = 0; j < W; j++) begin
                m = m * 2 + bits[k+j];
                l = l + (int'(bits[k+j]) << j);
            end
            e.is_err = 1'b0;
            e.w_msb  = m[W-1:0];
            e.w_lsb  = l[W-1:0];
            exp_q.push_back(e);
        end
        if (n % W != 0) begin
            e.is_err = 1'b1;
            e.w_msb  = '0;
            e.w_lsb  = '0;
            exp_q.push_back(e);
        end
    endtask

    task automatic monitor();
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < NDUT; d++) begin
                if (dv[d] === 1'b1 || ferr[d] === 1'b1) begin
                    check($sformatf("dut%0d valid_err_exclusive", d), 32'(dv[d] & ferr[d]), 0);
                    if (dv[d] === 1'b1) begin
                        check($sformatf("dut%0d valid_one_cycle", d), 32'(prev_dv[d]), 0);
                        dv_cnt[d]++;
                        dv_cyc_prev[d] = dv_cyc[d];
                        dv_cyc[d] = cyc;
                    end
                    if (ferr[d] === 1'b1) begin
                        check($sformatf("dut%0d err_one_cycle", d), 32'(prev_fe[d]), 0);
                        ferr_cnt[d]++;
                    end
                    if (rd_idx[d] >= exp_q.size()) begin
                        check($sformatf("dut%0d unexpected_event", d), 1, 0);
                    end else begin
                        ev_t e;
                        e = exp_q[rd_idx[d]];
                        rd_idx[d]++;
                        check($sformatf("dut%0d event_kind", d), 32'(ferr[d]), 32'(e.is_err));
                        if (dv[d] === 1'b1)
                            check($sformatf("dut%0d word", d), 32'(dout[d]), 32'((d == 1) ? e.w_lsb : e.w_msb));
                    end
                end
                prev_dv[d] = dv[d];
                prev_fe[d] = ferr[d];
            end
        end
    endtask

    // slow=0: synchronous clk/2 sclk; slow=1: clk/8 sclk with arbitrary phase.
    // cs_with_last raises cs_l together with the final sclk rise.
    // rst_at >= 0 pulses reset for two bits starting at that bit index.
    task automatic send_frame(input bit bits[$], input bit slow, input bit cs_with_last, input int rst_at);
        int n;
        n = bits.size();
        if (!slow) begin
            @(negedge clk);
            spi_cs_l = 1'b0;
            repeat (2) @(negedge clk);
            for (int i = 0; i < n; i++) begin
                if (i == rst_at) reset = 1'b1;
                if (i == rst_at + 2) reset = 1'b0;
                spi_data = bits[i];
                @(negedge clk);
                spi_sclk = 1'b1;
                if (i == n - 1 && cs_with_last) spi_cs_l = 1'b1;
                last_e1 = cyc + 1;
                @(negedge clk);
                spi_sclk = 1'b0;
            end
            @(negedge clk);
            spi_cs_l = 1'b1;
            repeat (3) @(negedge clk);
        end else begin
            int off;
            @(negedge clk);
            off = $urandom_range(1, 8);
            if (off >= 5) off++;
            #(off);
            spi_cs_l = 1'b0;
            #80;
            for (int i = 0; i < n; i++) begin
                spi_data = bits[i];
                #40;
                spi_sclk = 1'b1;
                #40;
                spi_sclk = 1'b0;
            end
            #40;
            spi_cs_l = 1'b1;
            #80;
            @(negedge clk);
        end
    endtask

    task automatic word_bits(input logic [W-1:0] w, input int nbits, output bit bits[$]);
        bits = {};
        for (int i = 0; i < nbits; i++) bits.push_back(w[W-1-i]);
    endtask

    initial begin
        vec_t vecs[8];
        bit   bits[$];
        bit   tmp[$];
        int   dv0 [NDUT];
        int   fe0 [NDUT];

        vecs[0] = '{16'hA569, 16, 16'hA569, 16'h96A5, 0};
        vecs[1] = '{16'h2563, 16, 16'h2563, 16'hC6A4, 0};
        vecs[2] = '{16'h6A61, 16, 16'h6A61, 16'h8656, 0};
        vecs[3] = '{16'hA265, 16, 16'hA265, 16'hA645, 0};
        vecs[4] = '{16'h7564, 16, 16'h7564, 16'h26AE, 0};
        vecs[5] = '{16'hFFFF,  7, 16'h7564, 16'h26AE, 1};
        vecs[6] = '{16'h1234, 16, 16'h1234, 16'h2C48, 0};
        vecs[7] = '{16'h96A5, 16, 16'h96A5, 16'hA569, 0};

        for (int d = 0; d < NDUT; d++) begin
            rd_idx[d] = 0; dv_cnt[d] = 0; ferr_cnt[d] = 0;
            dv_cyc[d] = 0; dv_cyc_prev[d] = 0; prev_dv[d] = 0; prev_fe[d] = 0;
        end
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("dut%0d reset dataout", d), 32'(dout[d]), 0);
            check($sformatf("dut%0d reset data_valid", d), 32'(dv[d]), 0);
            check($sformatf("dut%0d reset frame_err", d), 32'(ferr[d]), 0);
            check($sformatf("dut%0d reset bit_count", d), 32'(bc[d]), 0);
            check($sformatf("dut%0d reset busy", d), 32'(bsy[d]), 0);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            for (int d = 0; d < NDUT; d++) begin
                dv0[d] = dv_cnt[d];
                fe0[d] = ferr_cnt[d];
            end
            word_bits(vecs[k].tx, vecs[k].nbits, bits);
            model_frame(bits);
            send_frame(bits, 1'b0, 1'b0, -1);
            repeat (6) @(negedge clk);
            $display("vector %0d: tx=%h bits=%0d dataout=%h/%h/%h", k, vecs[k].tx, vecs[k].nbits,
                     dout[0], dout[1], dout[2]);
            check($sformatf("vec%0d dataout msb", k), 32'(dout[0]), 32'(vecs[k].exp0));
            check($sformatf("vec%0d dataout lsb", k), 32'(dout[1]), 32'(vecs[k].exp1));
            check($sformatf("vec%0d dataout sync", k), 32'(dout[2]), 32'(vecs[k].exp0));
            for (int d = 0; d < NDUT; d++) begin
                check($sformatf("vec%0d dut%0d valid count", k, d), 32'(dv_cnt[d] - dv0[d]),
                      32'(vecs[k].exp_err ? 0 : 1));
                check($sformatf("vec%0d dut%0d err count", k, d), 32'(ferr_cnt[d] - fe0[d]),
                      32'(vecs[k].exp_err));
                check($sformatf("vec%0d dut%0d bit_count idle", k, d), 32'(bc[d]), 0);
            end
            if (k == 0) begin
                for (int d = 0; d < NDUT; d++)
                    check($sformatf("dut%0d latency", d), 32'(dv_cyc[d] - last_e1 + 1), 32'(LAT[d]));
            end
        end

        // Deselect coincident with the 16th sclk rise: bit dropped, frame error.
        word_bits(16'h5555, 16, bits);
        word_bits(16'h5555, 15, tmp);
        model_frame(tmp);
        for (int d = 0; d < NDUT; d++) dv0[d] = dv_cnt[d];
        send_frame(bits, 1'b0, 1'b1, -1);
        repeat (6) @(negedge clk);
        $display("cs-wins frame: dataout=%h/%h/%h", dout[0], dout[1], dout[2]);
        for (int d = 0; d < NDUT; d++)
            check($sformatf("cs_wins dut%0d no valid", d), 32'(dv_cnt[d] - dv0[d]), 0);
        check("cs_wins dataout kept", 32'(dout[0]), 32'h96A5);

        // Reset during bit 9 with cs_l held low: the rest of that frame is ignored.
        word_bits(16'hC3A5, 16, bits);
        for (int d = 0; d < NDUT; d++) dv0[d] = dv_cnt[d];
        send_frame(bits, 1'b0, 1'b0, 9);
        repeat (4) @(negedge clk);
        $display("reset-mid-frame: dataout=%h/%h/%h", dout[0], dout[1], dout[2]);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("midreset dut%0d no valid", d), 32'(dv_cnt[d] - dv0[d]), 0);
            check($sformatf("midreset dut%0d dataout cleared", d), 32'(dout[d]), 0);
        end
        word_bits(16'hBEEF, 16, bits);
        model_frame(bits);
        send_frame(bits, 1'b0, 1'b0, -1);
        repeat (6) @(negedge clk);
        $display("after reset frame: dataout=%h/%h/%h", dout[0], dout[1], dout[2]);
        check("post_reset dataout", 32'(dout[0]), 32'hBEEF);

        // Two words streamed inside one frame.
        word_bits(16'hDEAD, 16, bits);
        word_bits(16'hBEEF, 16, tmp);
        foreach (tmp[i]) bits.push_back(tmp[i]);
        model_frame(bits);
        for (int d = 0; d < NDUT; d++) begin dv0[d] = dv_cnt[d]; fe0[d] = ferr_cnt[d]; end
        send_frame(bits, 1'b0, 1'b0, -1);
        repeat (6) @(negedge clk);
        $display("streamed frame: dataout=%h/%h/%h", dout[0], dout[1], dout[2]);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("stream dut%0d valid count", d), 32'(dv_cnt[d] - dv0[d]), 2);
            check($sformatf("stream dut%0d no err", d), 32'(ferr_cnt[d] - fe0[d]), 0);
            check($sformatf("stream dut%0d word spacing", d), 32'(dv_cyc[d] - dv_cyc_prev[d]), 32);
        end

        // Random frames, mixing synchronous clk/2 and asynchronous clk/8 sclk.
        for (int r = 0; r < 24; r++) begin
            int  len;
            bit  slow;
            len  = $urandom_range(1, 40);
            slow = 1'($urandom_range(0, 1));
            bits = {};
            for (int i = 0; i < len; i++) bits.push_back(1'($urandom_range(0, 1)));
            model_frame(bits);
            send_frame(bits, slow, 1'b0, -1);
            repeat (6) @(negedge clk);
            $display("random %0d: len=%0d slow=%0d dataout=%h/%h/%h", r, len, slow,
                     dout[0], dout[1], dout[2]);
        end

        repeat (10) @(negedge clk);
        for (int d = 0; d < NDUT; d++)
            check($sformatf("dut%0d all events seen", d), 32'(rd_idx[d]), 32'(exp_q.size()));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
